// File: rtl/lampfpu_div_arbiter.sv
// Round-robin arbiter sharing one lampFPU divider among NREQ requesters.
// Operands are held stable in registers for the whole divide.
module lampfpu_div_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int RW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*DW-1:0] op1_i,
  input  logic [NREQ*DW-1:0] op2_i,
  input  logic [NREQ*RW-1:0] rnd_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rsp_valid_o,
  input  logic [NREQ-1:0]    rsp_ready_i,
  output logic [DW-1:0]      rsp_data_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             div_do_o,
  output logic             div_padv_o,
  output logic [RW-1:0]    div_rnd_o,
  output logic [DW-1:0]    div_op1_o,
  output logic [DW-1:0]    div_op2_o,
  input  logic             div_ready_i,
  input  logic             div_valid_i,
  input  logic [DW-1:0]    div_result_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_win;
  logic [DW-1:0] r_op1;
  logic [DW-1:0] r_op2;
  logic [RW-1:0] r_rnd;
  logic [DW-1:0] r_res;
  logic          r_err;

  logic w_any;
  logic w_idle;
  logic w_grant;
  logic w_stale;
  logic w_cap;
  logic w_ack;

  // first set request searching upward from r_ptr+1
  always_comb begin
    int w_j;
    w_win = '0;
    w_any = 1'b0;
    w_j   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_j = int'(r_ptr) + i;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (!w_any && req_i[w_j]) begin
        w_any = 1'b1;
        w_win = IW'(w_j);
      end
    end
  end

  assign w_idle  = (r_state == S_IDLE);
  assign w_stale = w_idle && div_valid_i && rst_n;
  assign w_grant = w_idle && w_any && div_ready_i
                && !div_valid_i && rst_n;
  assign w_cap   = (r_state == S_WAIT) && div_valid_i;
  assign w_ack   = (r_state == S_RESP) && rsp_ready_i[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (div_valid_i) w_next = S_RESP;
      S_RESP:  if (w_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IW'(NREQ - 1);
      r_idx <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_rnd <= '0;
      r_res <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_idx <= w_win;
        r_op1 <= op1_i[w_win*DW +: DW];
        r_op2 <= op2_i[w_win*DW +: DW];
        r_rnd <= rnd_i[w_win*RW +: RW];
      end
      if (w_cap) r_res <= div_result_i;
      if (w_ack) r_ptr <= r_idx;
      if (div_valid_i && r_state != S_WAIT) r_err <= 1'b1;
    end
  end

  always_comb begin
    gnt_o       = '0;
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (w_grant) gnt_o[w_win] = 1'b1;
    if (r_state == S_RESP) begin
      rsp_valid_o[r_idx] = 1'b1;
      rsp_data_o         = r_res;
    end
    busy_o     = !w_idle;
    err_o      = r_err;
    div_do_o   = (r_state == S_ISSUE);
    div_padv_o = w_stale || w_cap;
    div_rnd_o  = r_rnd;
    div_op1_o  = r_op1;
    div_op2_o  = r_op2;
  end

endmodule

// File: tb/tb_lampfpu_div_arbiter.sv
// Scoreboard bench for lampfpu_div_arbiter with a behavioural divider.
// Expected results are queued at grant and popped at response handshake.
module tb_lampfpu_div_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int RW   = 2;
  localparam int LAT  = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_i;
  logic [NREQ*DW-1:0] op1_i;
  logic [NREQ*DW-1:0] op2_i;
  logic [NREQ*RW-1:0] rnd_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    rsp_valid_o;
  logic [NREQ-1:0]    rsp_ready_i;
  logic [DW-1:0]      rsp_data_o;
  logic               busy_o;
  logic               err_o;
  logic               div_do_o;
  logic               div_padv_o;
  logic [RW-1:0]      div_rnd_o;
  logic [DW-1:0]      div_op1_o;
  logic [DW-1:0]      div_op2_o;
  logic               div_ready_i;
  logic               div_valid_i;
  logic [DW-1:0]      div_result_i;

  lampfpu_div_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .op1_i(op1_i), .op2_i(op2_i), .rnd_i(rnd_i),
    .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o), .err_o(err_o),
    .div_do_o(div_do_o), .div_padv_o(div_padv_o),
    .div_rnd_o(div_rnd_o), .div_op1_o(div_op1_o),
    .div_op2_o(div_op2_o), .div_ready_i(div_ready_i),
    .div_valid_i(div_valid_i), .div_result_i(div_result_i)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // stand-in for the divider: 3.0/2.0 is exact, else a keyed hash
  function automatic logic [DW-1:0] fdiv(input logic [DW-1:0] a,
      input logic [DW-1:0] b, input logic [RW-1:0] r);
    if (a == 16'h4040 && b == 16'h4000) return 16'h3FC0;
    return (a + {b[7:0], b[15:8]}) ^ {{(DW-RW){1'b0}}, r};
  endfunction

  logic m_busy;
  logic m_valid;
  logic stale;
  int   m_cnt;

  assign div_valid_i = m_valid | stale;
  assign div_ready_i = !m_busy && !m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_valid <= 1'b0;
      m_cnt <= 0;
      div_result_i <= '0;
    end else begin
      if (div_do_o) begin
        m_busy <= 1'b1;
        m_cnt <= LAT;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_valid <= 1'b1;
          div_result_i <= fdiv(div_op1_o, div_op2_o, div_rnd_o);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (m_valid && div_padv_o) m_valid <= 1'b0;
    end
  end

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   glog[$];

  always @(negedge clk) begin : mon
    exp_t e;
    int   k;
    if (rst_n) begin
      chk("gnt_onehot", 32'($onehot0(gnt_o)), 32'd1);
      chk("rsp_onehot", 32'($onehot0(rsp_valid_o)), 32'd1);
      chk("do_padv_excl", 32'(div_do_o & div_padv_o), 32'd0);
      if (gnt_o != '0) begin
        k = 0;
        for (int i = 0; i < NREQ; i++) if (gnt_o[i]) k = i;
        e.idx  = k;
        e.data = fdiv(op1_i[k*DW +: DW], op2_i[k*DW +: DW],
                      rnd_i[k*RW +: RW]);
        sbq.push_back(e);
        glog.push_back(k);
      end
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 32'(rsp_valid_o), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_idx", 32'(rsp_valid_o), 32'(4'b0001 << e.idx));
          chk("rsp_data", 32'(rsp_data_o), 32'(e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [RW-1:0] r);
    op1_i[k*DW +: DW] = a;
    op2_i[k*DW +: DW] = b;
    rnd_i[k*RW +: RW] = r;
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (gnt_o == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(gnt_o != '0), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (rsp_valid_o == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rsp_valid_o != '0), 32'd1);
  endtask

  task automatic check_zero(input string t);
    chk({t, "_gnt"}, 32'(gnt_o), 32'd0);
    chk({t, "_rspv"}, 32'(rsp_valid_o), 32'd0);
    chk({t, "_rspd"}, 32'(rsp_data_o), 32'd0);
    chk({t, "_busy"}, 32'(busy_o), 32'd0);
    chk({t, "_err"}, 32'(err_o), 32'd0);
    chk({t, "_do"}, 32'(div_do_o), 32'd0);
    chk({t, "_padv"}, 32'(div_padv_o), 32'd0);
    chk({t, "_rnd"}, 32'(div_rnd_o), 32'd0);
    chk({t, "_op1"}, 32'(div_op1_o), 32'd0);
    chk({t, "_op2"}, 32'(div_op2_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [RW-1:0]   r;
    logic [NREQ-1:0] v;
    logic [DW-1:0]   d;
    int              n;

    rst_n = 1'b0;
    req_i = '0;
    rsp_ready_i = '0;
    op1_i = '0;
    op2_i = '0;
    rnd_i = '0;
    stale = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    tick();
    rst_n = 1'b1;

    // single divide 3.0 / 2.0
    tick();
    set_op(0, 16'h4040, 16'h4000, 2'd0);
    req_i = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt_o), 32'h1);
    tick();
    req_i = '0;
    @(negedge clk);
    chk("t1_do", 32'(div_do_o), 32'd1);
    chk("t1_gnt_pulse", 32'(gnt_o), 32'd0);
    chk("t1_op1", 32'(div_op1_o), 32'h4040);
    chk("t1_op2", 32'(div_op2_o), 32'h4000);
    n = 0;
    @(negedge clk);
    while (!div_valid_i && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t1_padv", 32'(div_padv_o), 32'd1);
    @(negedge clk);
    chk("t1_rspv", 32'(rsp_valid_o), 32'h1);
    chk("t1_rspd", 32'(rsp_data_o), 32'h3FC0);
    repeat (2) @(negedge clk);
    chk("t1_hold_v", 32'(rsp_valid_o), 32'h1);
    chk("t1_hold_d", 32'(rsp_data_o), 32'h3FC0);
    tick();
    rsp_ready_i = 4'hF;
    wait_idle("t1_idle");

    // round-robin from a fresh reset
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NREQ; k++)
      set_op(k, 16'(16'h1000 + k * 16'h0111),
             16'(16'h2000 + k), RW'(k));
    glog.delete();
    req_i = 4'hF;
    n = 0;
    while (glog.size() < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rr_count", 32'(glog.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      chk("rr_order", 32'(glog[i]), 32'(i % NREQ));
    tick();
    req_i = '0;
    wait_idle("rr_idle");

    // operand stability: owner scrambles its inputs after grant
    a = 16'h4500;
    b = 16'h3C80;
    r = 2'd3;
    tick();
    set_op(2, a, b, r);
    req_i = 4'b0100;
    wait_gnt("os_gnt");
    chk("os_gnt_idx", 32'(gnt_o), 32'h4);
    n = 0;
    do begin
      tick();
      req_i = '0;
      set_op(2, 16'($urandom), 16'($urandom), RW'($urandom));
      @(negedge clk);
      chk("os_op1", 32'(div_op1_o), 32'(a));
      chk("os_op2", 32'(div_op2_o), 32'(b));
      chk("os_rnd", 32'(div_rnd_o), 32'(r));
      n++;
    end while (busy_o && n < 100);
    chk("os_idle", 32'(busy_o), 32'd0);

    // response backpressure with two contenders
    tick();
    rsp_ready_i = '0;
    set_op(1, 16'h4200, 16'h4100, 2'd1);
    set_op(2, 16'h4400, 16'h3E00, 2'd2);
    req_i = 4'b0110;
    wait_rsp("bp_rsp");
    v = rsp_valid_o;
    d = rsp_data_o;
    chk("bp_owner", 32'(v), 32'h2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_v", 32'(rsp_valid_o), 32'(v));
      chk("bp_d", 32'(rsp_data_o), 32'(d));
      chk("bp_gnt", 32'(gnt_o), 32'd0);
      chk("bp_do", 32'(div_do_o), 32'd0);
    end
    tick();
    rsp_ready_i = 4'hF;
    wait_gnt("bp_gnt2");
    chk("bp_gnt2_idx", 32'(gnt_o), 32'h4);
    tick();
    req_i = '0;
    wait_idle("bp_idle");

    // stale divider valid while idle
    tick();
    stale = 1'b1;
    set_op(0, 16'h4880, 16'h4000, 2'd0);
    req_i = 4'b0001;
    @(negedge clk);
    chk("st_padv", 32'(div_padv_o), 32'd1);
    chk("st_gnt", 32'(gnt_o), 32'd0);
    chk("st_err_pre", 32'(err_o), 32'd0);
    tick();
    stale = 1'b0;
    @(negedge clk);
    chk("st_err", 32'(err_o), 32'd1);
    chk("st_gnt_after", 32'(gnt_o), 32'h1);
    tick();
    req_i = '0;
    wait_idle("st_idle");
    chk("st_err_sticky", 32'(err_o), 32'd1);

    // asynchronous reset in the middle of a divide
    tick();
    set_op(1, 16'h4300, 16'h4000, 2'd1);
    req_i = 4'b0010;
    wait_gnt("rw_gnt");
    tick();
    req_i = 4'hF;
    @(negedge clk);
    chk("rw_do", 32'(div_do_o), 32'd1);
    repeat (2) @(negedge clk);
    chk("rw_busy", 32'(busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rw");
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rw_first", 32'(gnt_o), 32'h1);
    tick();
    req_i = '0;
    wait_idle("rw_idle");

    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
